piso_serializer: RTL and testbench

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 88 ++++++++
 tb/tb_piso_serializer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter, MSB first, load/shift handshake
// Optional macro PISO_SERIALIZER_PARITY_EN appends an even-parity bit after the LSB.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift_enable,
  output logic             data,
  output logic             busy,
  output logic             ready,
  output logic             done
);

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [FRAME_LEN-1:0] r_shreg;
  logic [CW-1:0]        r_cnt;
  logic                 r_done;
  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_accept;
  logic                 w_shift;
  logic                 w_last;

`ifdef PISO_SERIALIZER_PARITY_EN
  assign w_frame = {din, ^din};
`else
  assign w_frame = din;
`endif

  // Load wins over shift in IDLE; shift_enable only matters once a frame is active.
  assign w_accept = (r_state == IDLE) && load;
  assign w_shift  = (r_state == SHIFT) && shift_enable;
  assign w_last   = w_shift && (r_cnt == CW'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (load)   w_next = SHIFT;
      SHIFT:   if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == SHIFT);
    ready = (r_state != SHIFT);
    data  = (r_state == SHIFT) ? r_shreg[FRAME_LEN-1] : 1'b0;
    done  = r_done;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_shreg <= w_frame;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shreg <= {r_shreg[FRAME_LEN-2:0], 1'b0};
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - scoreboard bench for piso_serializer (WIDTH=8)
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] din;
  logic       shift_enable;
  logic       data;
  logic       busy;
  logic       ready;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic exp_q[$];
  logic m_busy = 1'b0;
  logic m_done = 1'b0;
  int   m_cnt  = 0;

  piso_serializer #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .din          (din),
    .shift_enable (shift_enable),
    .data         (data),
    .busy         (busy),
    .ready        (ready),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic exp_data;
    exp_data = (m_busy && exp_q.size() > 0) ? exp_q[0] : 1'b0;
    chk({tag, ".busy"},  busy,  m_busy);
    chk({tag, ".ready"}, ready, ~m_busy);
    chk({tag, ".done"},  done,  m_done);
    chk({tag, ".data"},  data,  exp_data);
  endtask

  // One clock: drive inputs, advance the reference model at the edge, check after it.
  task automatic cyc(input string tag, input logic l, input logic [7:0] d, input logic se);
    logic dummy;
    load = l;
    din = d;
    shift_enable = se;
    @(posedge clk);
    m_done = 1'b0;
    if (!m_busy) begin
      if (l) begin
        for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PISO_SERIALIZER_PARITY_EN
        exp_q.push_back(^d);
`endif
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else if (se) begin
      if (exp_q.size() > 0) dummy = exp_q.pop_front();
      m_cnt++;
      if (m_cnt == FL) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_cnt  = 0;
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    load         = 1'b0;
    din          = 8'h00;
    shift_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset_n = 1'b1;

    // A5, continuous shifting; done and busy-fall on the final enabled edge
    cyc("a5_load", 1'b1, 8'hA5, 1'b0);
    repeat (FL) cyc("a5_shift", 1'b0, 8'h00, 1'b1);
    cyc("a5_idle", 1'b0, 8'h00, 1'b0);

    // C3 with gaps in shift_enable
    cyc("c3_load", 1'b1, 8'hC3, 1'b0);
    begin
      logic [9:0] pat;
      pat = 10'b1001101111;
      for (int i = 9; i >= 0; i--) cyc("c3_gap", 1'b0, 8'h00, pat[i]);
    end
    while (m_busy) cyc("c3_tail", 1'b0, 8'h00, 1'b1);
    cyc("c3_idle", 1'b0, 8'h00, 1'b0);

    // F0 frame with loads of 0F hammered during it, then back-to-back 0F
    cyc("f0_load", 1'b1, 8'hF0, 1'b0);
    repeat (FL) cyc("f0_ignore", 1'b1, 8'h0F, 1'b1);
    cyc("0f_b2b", 1'b1, 8'h0F, 1'b0);
    repeat (FL) cyc("0f_shift", 1'b0, 8'h00, 1'b1);
    cyc("0f_idle", 1'b0, 8'h00, 1'b0);

    // Reset after 3 bits of FF aborts without done; then a clean 81 frame
    cyc("ff_load", 1'b1, 8'hFF, 1'b0);
    repeat (3) cyc("ff_shift", 1'b0, 8'h00, 1'b1);
    reset_pulse("ff_abort");
    cyc("post_rst", 1'b0, 8'h00, 1'b0);
    cyc("81_load", 1'b1, 8'h81, 1'b0);
    repeat (FL) cyc("81_shift", 1'b0, 8'h00, 1'b1);
    cyc("81_idle", 1'b0, 8'h00, 1'b0);

    // Load and shift together in IDLE: the load cycle is not a shift
    cyc("80_load_se", 1'b1, 8'h80, 1'b1);
    cyc("80_hold1", 1'b0, 8'h00, 1'b0);
    cyc("80_hold2", 1'b0, 8'h00, 1'b0);
    chk("80_first_bit", data, 1'b1);
    repeat (FL) cyc("80_shift", 1'b0, 8'h00, 1'b1);
    cyc("80_idle", 1'b0, 8'h00, 1'b0);

    // Shift enable in IDLE has no effect
    repeat (2) cyc("idle_se", 1'b0, 8'h55, 1'b1);

`ifdef PISO_SERIALIZER_PARITY_EN
    cyc("par_a5_load", 1'b1, 8'hA5, 1'b0);
    repeat (8) cyc("par_a5_shift", 1'b0, 8'h00, 1'b1);
    chk("par_a5_bit9", data, 1'b0);
    cyc("par_a5_last", 1'b0, 8'h00, 1'b1);
    chk("par_a5_done", done, 1'b1);
    cyc("par_01_load", 1'b1, 8'h01, 1'b0);
    repeat (8) cyc("par_01_shift", 1'b0, 8'h00, 1'b1);
    chk("par_01_bit9", data, 1'b1);
    cyc("par_01_last", 1'b0, 8'h00, 1'b1);
    chk("par_01_done", done, 1'b1);
    cyc("par_idle", 1'b0, 8'h00, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
